audio_out_unit: RTL and testbench

Audio output stage downstream of the processor datapath. It accepts 11-bit samples from the datapath's audio register (R6) using a four-phase request/acknowledge handshake on the R14/R13 flags. Accepted samples are buffered in a small FIFO, drained at a fixed sample rate, and converted to a single-bit PWM stream for the board's audio pin.

---
 rtl/audio_out_pkg.sv | 16 +
 rtl/audio_out_unit_sync_fifo.sv | 66 ++++++
 rtl/audio_out_unit.sv | 129 ++++++++++++
 tb/tb_audio_out_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
// Shared widths, reset constants and the handshake state encoding for the
// audio output stage.
package audio_out_pkg;

    localparam int AUDIO_W = 11;
    localparam int PWM_W   = 11;

    // Midscale sample, so the output idles at 50% duty (silence).
    localparam logic [AUDIO_W-1:0] MIDSCALE = 11'd1024;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

endpackage

// File: rtl/audio_out_unit_sync_fifo.sv
// Single-clock FIFO with a combinational head read (rdata shows the oldest
// entry). Pointers wrap modulo DEPTH, which must be a power of two.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign rdata = mem_q[rptr_q];

    // Pointer and occupancy next-state; simultaneous push and pop leave count unchanged.
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/audio_out_unit.sv
// Audio output stage: four-phase req/ack sample intake into a FIFO, fixed-rate
// drain on a sample tick, and an 11-bit glitch-free PWM for the audio pin.
// Optional feature macro: AUDIO_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun counter and the underrun_cnt port.
module audio_out_unit
    import audio_out_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int SAMPLE_DIV = 6250
) (
    input  logic                   clkFPGA,
    input  logic                   rst,
    input  logic [10:0]            sample_in,
    input  logic                   req,
    output logic                   ack,
    output logic                   pwm_out,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef AUDIO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]            underrun_cnt
`endif
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

    logic               req_meta_q, req_s_q;
    hs_state_t          state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick;
    logic [AUDIO_W-1:0] pend_sample_q, pend_sample_d;
    logic [AUDIO_W-1:0] act_sample_q, act_sample_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic               pwm_out_q, pwm_out_d;
    logic               push, pop, full, empty;
    logic [AUDIO_W-1:0] rdata;

    sync_fifo #(
        .WIDTH (AUDIO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clkFPGA),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .wdata (sample_in),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Handshake next-state: accept when room exists, release once req drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HS_IDLE: if (req_s_q && !full) state_d = HS_ACK;
            HS_ACK:  if (!req_s_q)         state_d = HS_IDLE;
            default: state_d = HS_IDLE;
        endcase
    end

    // Handshake outputs: the push lands on the same edge that raises ack.
    always_comb begin
        ack  = (state_q == HS_ACK);
        push = (state_q == HS_IDLE) && req_s_q && !full;
    end

    // Sample tick divider, pop/underrun handling and PWM datapath.
    always_comb begin
        tick          = (tick_cnt_q == TICK_LAST);
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        pop           = tick && !empty;
        pend_sample_d = pop ? rdata : pend_sample_q;
        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        // Reload only as the counter wraps so a period is never split.
        act_sample_d  = (pwm_cnt_q == '1) ? pend_sample_q : act_sample_q;
        pwm_out_d     = (pwm_cnt_q < act_sample_q);
    end

    // All registered state, cleared asynchronously.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            req_meta_q    <= 1'b0;
            req_s_q       <= 1'b0;
            state_q       <= HS_IDLE;
            tick_cnt_q    <= '0;
            pend_sample_q <= MIDSCALE;
            act_sample_q  <= MIDSCALE;
            pwm_cnt_q     <= '0;
            pwm_out_q     <= 1'b0;
        end else begin
            req_meta_q    <= req;
            req_s_q       <= req_meta_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            pend_sample_q <= pend_sample_d;
            act_sample_q  <= act_sample_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pwm_out_q     <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;

`ifdef AUDIO_UNDERRUN_CNT_EN
    logic [15:0] underrun_q, underrun_d;

    // Count ticks that find the FIFO empty, saturating at all-ones.
    always_comb begin
        underrun_d = underrun_q;
        if (tick && empty && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_audio_out_unit.sv
// Directed bench for audio_out_unit with a short sample period (400 cycles).
module tb_audio_out_unit;

    localparam int DEPTH = 8;
    localparam int SDIV  = 400;

    typedef struct {
        logic [10:0] sample;
        int          exp_level;
    } hs_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] sample_in;
    logic        req;
    logic        ack;
    logic        pwm_out;
    logic [3:0]  fifo_level;
`ifdef AUDIO_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;
    int hi_cnt [4];

    always #5 clk = ~clk;

    audio_out_unit #(
        .DEPTH      (DEPTH),
        .SAMPLE_DIV (SDIV)
    ) dut (
        .clkFPGA    (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .req        (req),
        .ack        (ack),
        .pwm_out    (pwm_out),
        .fifo_level (fifo_level)
`ifdef AUDIO_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    // Edges since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // High-cycle count of pwm_out per 2048-cycle window after release.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) hi_cnt[i] <= 0;
        end else if (cyc >= 1 && cyc <= 8192 && pwm_out === 1'b1) begin
            hi_cnt[(cyc - 1) / 2048] <= hi_cnt[(cyc - 1) / 2048] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_hs(input logic [10:0] s, input int exp_level);
        sample_in = s;
        req = 1'b1;
        step();
        step();
        chk("hs_ack_early", 32'(ack), 0);
        step();
        chk("hs_ack_rise", 32'(ack), 1);
        chk("hs_level", 32'(fifo_level), 32'(exp_level));
        req = 1'b0;
        step();
        step();
        chk("hs_ack_hold", 32'(ack), 1);
        step();
        chk("hs_ack_fall", 32'(ack), 0);
    endtask

    hs_vec_t fill [7];

    initial begin
        fill[0] = '{11'd100,  2};
        fill[1] = '{11'd200,  3};
        fill[2] = '{11'd400,  4};
        fill[3] = '{11'd2047, 5};
        fill[4] = '{11'd500,  6};
        fill[5] = '{11'd700,  7};
        fill[6] = '{11'd900,  8};

        rst = 1'b1;
        req = 1'b0;
        sample_in = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_level", 32'(fifo_level), 0);
`ifdef AUDIO_UNDERRUN_CNT_EN
        chk("rst_underrun", 32'(underrun_cnt), 0);
`endif
        repeat (3) step();
        rst = 1'b1;

        // Three ticks on an empty FIFO.
        wait_until(SDIV * 3 + 1);
        chk("underrun_pend", 32'(dut.pend_sample_q), 1024);
`ifdef AUDIO_UNDERRUN_CNT_EN
        chk("underrun_cnt3", 32'(underrun_cnt), 3);
`endif

        // Reset in the middle of a handshake, req held across release.
        sample_in = 11'd300;
        req = 1'b1;
        repeat (3) step();
        chk("pre_rst_ack", 32'(ack), 1);
        chk("pre_rst_level", 32'(fifo_level), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_pwm", 32'(pwm_out), 0);
`ifdef AUDIO_UNDERRUN_CNT_EN
        chk("mid_rst_underrun", 32'(underrun_cnt), 0);
`endif
        repeat (2) step();
        rst = 1'b1;
        step();
        step();
        chk("single_ack_c2", 32'(ack), 0);
        step();
        chk("single_ack_c3", 32'(ack), 1);
        chk("single_level", 32'(fifo_level), 1);
        req = 1'b0;
        step();
        step();
        chk("single_ack_hold", 32'(ack), 1);
        step();
        chk("single_ack_drop", 32'(ack), 0);

        // Fill to DEPTH before the first tick.
        for (int i = 0; i < 7; i++) do_hs(fill[i].sample, fill[i].exp_level);

        // Ninth request is held off until a tick frees an entry.
        sample_in = 11'd1100;
        req = 1'b1;
        wait_until(60);
        chk("bp_ack_60", 32'(ack), 0);
        chk("bp_level_60", 32'(fifo_level), 8);
        wait_until(SDIV - 1);
        chk("bp_ack_399", 32'(ack), 0);
        step();
        chk("bp_pop_level", 32'(fifo_level), 7);
        chk("bp_pop_ack", 32'(ack), 0);
        chk("bp_pop_oldest", 32'(dut.pend_sample_q), 300);
        step();
        chk("bp_accept_ack", 32'(ack), 1);
        chk("bp_accept_level", 32'(fifo_level), 8);
        req = 1'b0;
        repeat (3) step();
        chk("bp_ack_drop", 32'(ack), 0);

        wait_until(2049);
        chk("duty_midscale", 32'(hi_cnt[0]), 1024);

        wait_until(SDIV * 6);
        chk("drain_level3", 32'(fifo_level), 3);
        chk("drain_pend", 32'(dut.pend_sample_q), 500);

        // Push lands on the same edge as the tick pop.
        wait_until(SDIV * 7 - 3);
        sample_in = 11'd0;
        req = 1'b1;
        step();
        step();
        chk("simul_level_pre", 32'(fifo_level), 3);
        chk("simul_ack_pre", 32'(ack), 0);
        step();
        chk("simul_level", 32'(fifo_level), 3);
        chk("simul_ack", 32'(ack), 1);
        chk("simul_oldest", 32'(dut.pend_sample_q), 700);
        req = 1'b0;
        repeat (3) step();
        chk("simul_ack_drop", 32'(ack), 0);

        // Window 1 plays 2047 although pend changed several times mid-period.
        wait_until(4097);
        chk("duty_2047", 32'(hi_cnt[1]), 2047);
        chk("pend_zero", 32'(dut.pend_sample_q), 0);

        wait_until(6145);
        chk("duty_zero", 32'(hi_cnt[2]), 0);
        chk("final_level", 32'(fifo_level), 0);
`ifdef AUDIO_UNDERRUN_CNT_EN
        chk("final_underrun", 32'(underrun_cnt), 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
